mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the data and address width.
REQ-002 Parameter MAX_WAIT, default 8'd255, SHALL set the number of cycles spent in BUSY before a timeout.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 MemRead_m, MemWrite_m  input  1 each  SHALL be the load and store strobes from ex_mem.
REQ-006 nop_m, halt_m  input  1 each  SHALL mark a bubble or halting instruction; either SHALL suppress the access.
REQ-007 addr_m, wdata_m  input  DATA_W each  SHALL be the effective address and store data.
REQ-008 mem_req, mem_wr  output  1 each  SHALL be the access request pulse and its write qualifier to data memory.
REQ-009 mem_addr, mem_wdata  output  DATA_W each  SHALL be the address and store data presented with mem_req.
REQ-010 mem_rdata  input  DATA_W  SHALL be the read data from memory, valid only with mem_done.
REQ-011 mem_done  input  1  SHALL be the completion pulse from memory.
REQ-012 memResult_m  output  DATA_W  SHALL be the load result delivered to mem_wb.
REQ-013 stall  output  1  SHALL freeze fetch, ex_mem and mem_wb while high.
REQ-014 err  output  1  SHALL be a sticky error flag.

Function
REQ-015 The block SHALL contain an FSM with states IDLE, BUSY and DONE.
REQ-016 IDLE: access = (MemRead_m|MemWrite_m)&!nop_m&!halt_m; on access, drive mem_req=1 for exactly one cycle with mem_wr=MemWrite_m and mem_addr/mem_wdata from inputs, assert stall combinationally, and go to BUSY.
REQ-017 IDLE without access: stall=0, mem_req=0, memResult_m=0.
REQ-018 BUSY: stall=1 and mem_req=0; the wait counter SHALL increment each cycle.
REQ-019 BUSY: on mem_done, latch mem_rdata for a load (0 for a store) and go to DONE.
REQ-020 DONE: stall=0 and memResult_m=latched value; the next state SHALL be IDLE unconditionally, with no re-issue.
REQ-021 Latency: memory response after N cycles -> stall high N+1 cycles; result visible in cycle N+2.
REQ-022 Timeout: when the counter equals MAX_WAIT in BUSY without mem_done, set err=1, latch 0, and go to DONE.
REQ-023 mem_done simultaneous with timeout SHALL be treated as success, with no err.
REQ-024 mem_done arriving in IDLE or DONE SHALL be ignored.
REQ-025 The counter SHALL clear on BUSY entry and saturate, never wrap.
REQ-026 Back-to-back accesses SHALL each pass through DONE, giving a minimum 3-cycle spacing.

Reset
REQ-027 While rst=0, outputs SHALL be: state IDLE, mem_req=0, mem_wr=0, mem_addr=0, mem_wdata=0, memResult_m=0, stall=0, err=0, counter=0.
REQ-028 Reset asserted mid-BUSY SHALL abandon the access, with no mem_req on release until a new access arrives.
REQ-029 err SHALL clear only on reset.

Configuration
REQ-030 Macro MEM_ALIGN_CHECK_EN defined: access with addr_m[0]=1 SHALL issue no mem_req, SHALL set err, SHALL keep stall=0, and memResult_m SHALL be 0.
REQ-031 Macro MEM_ALIGN_CHECK_EN undefined: addr_m SHALL be passed unchanged with no alignment check.

Structure
REQ-032 Package mem_pkg SHALL hold the state encoding (IDLE/BUSY/DONE), DATA_W and MAX_WAIT defaults.
REQ-033 Sub-module mem_wait_cnt SHALL implement the clearable, saturating wait counter with a terminal-count output.
REQ-034 All flops SHALL use the team's asynchronous active-low reset flop.

Verification
REQ-035 Load addr 16'h0010, mem_done 3 cycles after mem_req with rdata 16'hBEEF -> stall high 4 cycles, memResult_m=16'hBEEF in the next cycle, err=0.
REQ-036 Store addr 16'h0020 wdata 16'h1234 -> a single mem_req with mem_wr=1 and the correct address/data; memResult_m=0 in DONE.
REQ-037 Load with mem_done never asserted -> err=1 after MAX_WAIT+1 BUSY cycles, then IDLE; a later load completes normally with err still 1.
REQ-038 Load with nop_m=1 or halt_m=1 -> no mem_req and stall=0 throughout.
REQ-039 rst dropped 2 cycles into BUSY -> all outputs 0 asynchronously; a late mem_done after release is ignored.
REQ-040 With MEM_ALIGN_CHECK_EN, load addr 16'h0011 -> no mem_req, err=1, stall=0; without the macro, mem_req is issued with mem_addr=16'h0011.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared state encoding, default sizing and access decode for the memory stage.
package mem_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] MAX_WAIT_DEF = 8'd255;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic is_access(input logic rd, input logic wr,
                                     input logic nop, input logic halt);
    return (rd | wr) & ~nop & ~halt;
  endfunction

endpackage

// File: rtl/mem_wait_cnt.sv
// Clearable wait counter that saturates at MAX and flags the terminal count.
module mem_wait_cnt import mem_pkg::*; #(
  parameter int W = CNT_W,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && cnt != MAX) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc = (cnt == MAX);

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues one data-memory access per load/store and stalls until it completes.
// Optional MEM_ALIGN_CHECK_EN rejects odd addresses with a sticky error instead of issuing them.
module mem_stage import mem_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter logic [CNT_W-1:0] MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead_m,
  input  logic              MemWrite_m,
  input  logic              nop_m,
  input  logic              halt_m,
  input  logic [DATA_W-1:0] addr_m,
  input  logic [DATA_W-1:0] wdata_m,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  output logic [DATA_W-1:0] memResult_m,
  output logic              stall,
  output logic              err,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  wait_cnt
);

  // Memory handshake: mem_req is a one-cycle pulse carrying mem_wr/mem_addr/mem_wdata;
  // memory answers later with a one-cycle mem_done, mem_rdata valid only in that cycle.
  logic [1:0]        state_q, state_d;
  logic              access, misaligned, issue, in_busy, in_idle, timeout, tc;
  logic              is_store_q;
  logic [DATA_W-1:0] result_q;

  assign access = is_access(MemRead_m, MemWrite_m, nop_m, halt_m);

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = access & addr_m[0];
`else
  assign misaligned = 1'b0;
`endif

  assign in_idle = (state_q == ST_IDLE);
  assign in_busy = (state_q == ST_BUSY);
  // Reset gates the issue path so request outputs drop immediately with rst.
  assign issue   = rst & in_idle & access & ~misaligned;
  assign timeout = in_busy & tc & ~mem_done;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (issue) state_d = ST_BUSY;
      ST_BUSY: if (mem_done || tc) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      is_store_q <= 1'b0;
      result_q   <= '0;
      err        <= 1'b0;
    end else begin
      state_q <= state_d;
      if (issue) is_store_q <= MemWrite_m;
      // Completion wins over a coincident timeout.
      if (in_busy && mem_done) result_q <= is_store_q ? '0 : mem_rdata;
      else if (timeout)        result_q <= '0;
      if (timeout || (in_idle && misaligned)) err <= 1'b1;
    end
  end

  mem_wait_cnt #(.W(CNT_W), .MAX(MAX_WAIT)) u_wait_cnt (
    .clk (clk),
    .rst (rst),
    .clr (issue),
    .en  (in_busy),
    .cnt (wait_cnt),
    .tc  (tc)
  );

  assign mem_req     = issue;
  assign mem_wr      = issue & MemWrite_m;
  assign mem_addr    = issue ? addr_m : '0;
  assign mem_wdata   = issue ? wdata_m : '0;
  assign stall       = issue | in_busy;
  assign memResult_m = (state_q == ST_DONE) ? result_q : '0;
  assign state       = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: the bench plays data memory and predicts each access from latency arithmetic.
module tb_mem_stage;
  import mem_pkg::*;

  localparam int W  = 16;
  localparam int MW = 255;

  logic         clk = 1'b0;
  logic         rst;
  logic         MemRead_m, MemWrite_m, nop_m, halt_m;
  logic [W-1:0] addr_m, wdata_m;
  logic         mem_req, mem_wr;
  logic [W-1:0] mem_addr, mem_wdata, mem_rdata;
  logic         mem_done;
  logic [W-1:0] memResult_m;
  logic         stall, err;
  logic [1:0]   state;
  logic [7:0]   wait_cnt;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] exp_q[$];
  bit           err_model = 1'b0;

  mem_stage #(.DATA_W(W), .MAX_WAIT(8'(MW))) dut (
    .clk(clk), .rst(rst),
    .MemRead_m(MemRead_m), .MemWrite_m(MemWrite_m), .nop_m(nop_m), .halt_m(halt_m),
    .addr_m(addr_m), .wdata_m(wdata_m),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .memResult_m(memResult_m), .stall(stall), .err(err),
    .state(state), .wait_cnt(wait_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_inputs(input bit rd, input bit wr, input bit nop, input bit hlt,
                            input logic [W-1:0] a, input logic [W-1:0] wd);
    MemRead_m = rd; MemWrite_m = wr; nop_m = nop; halt_m = hlt;
    addr_m = a; wdata_m = wd;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"}, mem_req, 0);
    check({tag, "_wr"}, mem_wr, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_wdata"}, mem_wdata, 0);
    check({tag, "_result"}, memResult_m, 0);
    check({tag, "_stall"}, stall, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_state"}, state, ST_IDLE);
    check({tag, "_cnt"}, wait_cnt, 0);
  endtask

  // One instruction through the stage. lat = cycles from mem_req to mem_done, <0 = never.
  // Called and returns at posedge+1 with the stage in IDLE.
  task automatic run_access(input bit rd, input bit wr, input bit nop, input bit hlt,
                            input logic [W-1:0] a, input logic [W-1:0] wd,
                            input logic [W-1:0] rdat, input int lat);
    bit acc, mis, tmo, ended;
    int exp_stall, n_stall, n_req;
    acc = (rd || wr) && !nop && !hlt;
    mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    mis = acc && a[0];
`endif
    set_inputs(rd, wr, nop, hlt, a, wd);
    mem_done  = 1'($urandom_range(0, 1));
    mem_rdata = W'($urandom);
    @(negedge clk);
    if (!acc || mis) begin
      check("noacc_req", mem_req, 0);
      check("noacc_stall", stall, 0);
      check("noacc_result", memResult_m, 0);
      if (mis) err_model = 1'b1;
      @(posedge clk); #1;
      set_inputs(0, 0, 0, 0, '0, '0);
      mem_done = 1'b0;
      @(negedge clk);
      check("noacc_req2", mem_req, 0);
      check("noacc_stall2", stall, 0);
      check("noacc_err", err, err_model);
      @(posedge clk); #1;
      return;
    end
    check("issue_req", mem_req, 1);
    check("issue_wr", mem_wr, wr);
    check("issue_addr", mem_addr, a);
    check("issue_wdata", mem_wdata, wd);
    check("issue_stall", stall, 1);
    check("issue_result", memResult_m, 0);

    tmo       = (lat < 0) || (lat > MW + 1);
    exp_stall = tmo ? MW + 2 : lat + 1;
    exp_q.push_back(tmo ? '0 : (wr ? '0 : rdat));
    if (tmo) err_model = 1'b1;

    n_stall = 1; n_req = 0; ended = 1'b0;
    for (int c = 1; c <= MW + 4 && !ended; c++) begin
      @(posedge clk); #1;
      mem_done  = (c == lat);
      mem_rdata = (c == lat) ? rdat : W'($urandom);
      @(negedge clk);
      if (mem_req) n_req++;
      if (stall) n_stall++;
      else ended = 1'b1;
    end
    check("done_reached", ended, 1);
    check("stall_cycles", n_stall, exp_stall);
    check("busy_extra_req", n_req, 0);
    check("result", memResult_m, exp_q.pop_front());
    check("err", err, err_model);

    // Next cycle is IDLE: instruction retired, stray completion must be ignored.
    @(posedge clk); #1;
    set_inputs(0, 0, 0, 0, '0, '0);
    mem_done = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("post_req", mem_req, 0);
    check("post_stall", stall, 0);
    check("post_result", memResult_m, 0);
    @(posedge clk); #1;
    mem_done = 1'b0;
  endtask

  initial begin
    #500000;
    n_errors++;
    $display("FAIL watchdog: time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    set_inputs(0, 0, 0, 0, '0, '0);
    mem_done = 1'b0; mem_rdata = '0;
    #2;
    check_all_zero("reset");
    // A load presented while in reset must not reach memory.
    set_inputs(1, 0, 0, 0, 16'h0010, 16'h0);
    #1;
    check("reset_load_req", mem_req, 0);
    check("reset_load_stall", stall, 0);
    @(posedge clk); #1;
    set_inputs(0, 0, 0, 0, '0, '0);
    rst = 1'b1;
    @(posedge clk); #1;

    run_access(1, 0, 0, 0, 16'h0010, 16'h0000, 16'hBEEF, 3);
    run_access(0, 1, 0, 0, 16'h0020, 16'h1234, 16'h5555, 2);
    run_access(1, 0, 1, 0, 16'h0030, 16'h0000, 16'h1111, 2);
    run_access(1, 0, 0, 1, 16'h0032, 16'h0000, 16'h1111, 2);
    run_access(1, 0, 0, 0, 16'h0034, 16'h0000, 16'h0F0F, 1);
    // mem_done in the same cycle the counter hits MAX_WAIT is a success
    run_access(1, 0, 0, 0, 16'h0044, 16'h0000, 16'h7777, MW + 1);
    run_access(1, 0, 0, 0, 16'h0011, 16'h0000, 16'h2222, 2);
    // never answered, then a late answer one cycle past the limit
    run_access(1, 0, 0, 0, 16'h0040, 16'h0000, 16'hAAAA, -1);
    run_access(1, 0, 0, 0, 16'h0042, 16'h0000, 16'hCAFE, 4);
    run_access(1, 0, 0, 0, 16'h0046, 16'h0000, 16'h3333, MW + 2);

    // Reset dropped two cycles into BUSY.
    set_inputs(1, 0, 0, 0, 16'h0050, 16'h0);
    @(negedge clk);
    check("rstmid_issue", mem_req, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rstmid_busy", stall, 1);
    #1;
    rst = 1'b0;
    err_model = 1'b0;
    #1;
    check_all_zero("rstmid");
    set_inputs(0, 0, 0, 0, '0, '0);
    @(posedge clk); #1;
    rst = 1'b1;
    mem_done = 1'b1; mem_rdata = 16'hDEAD;
    @(negedge clk);
    check("late_done_req", mem_req, 0);
    check("late_done_stall", stall, 0);
    check("late_done_result", memResult_m, 0);
    check("late_done_state", state, ST_IDLE);
    @(posedge clk); #1;
    mem_done = 1'b0;
    @(negedge clk);
    check("late_done_result2", memResult_m, 0);
    check("late_done_err", err, 0);
    @(posedge clk); #1;

    repeat (40) begin
      bit rd, wr, nop, hlt;
      int lat;
      rd  = 1'($urandom_range(0, 1));
      wr  = ($urandom_range(0, 3) == 0);
      nop = ($urandom_range(0, 7) == 0);
      hlt = ($urandom_range(0, 7) == 0);
      lat = $urandom_range(1, 12);
      run_access(rd, wr, nop, hlt, W'($urandom), W'($urandom), W'($urandom), lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
